// File: rtl/shift_reg_universal.sv
// shift_reg_universal: parametrised universal shift register.
//
// Per-cycle mode select (hold / shift right / shift left / parallel load) with
// serial in/out at both ends. A saturating shift counter reports how many
// shifts have happened since the last load or reset, and done pulses for one
// cycle on the WIDTH-th shift so a PISO user knows the word has left.
//
// Optional feature macro: ROTATE_EN. When defined, the rot port exists and
// rot=1 makes shifts wrap around instead of taking sin_msb/sin_lsb.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset_n   in   1      asynchronous active-low reset
//   mode      in   2      00 hold, 01 shift right, 10 shift left, 11 load
//   d         in   WIDTH  parallel load data
//   sin_msb   in   1      serial input entering at MSB on shift right
//   sin_lsb   in   1      serial input entering at LSB on shift left
//   rot       in   1      (ROTATE_EN only) 1 = shifts wrap
//   q         out  WIDTH  register contents
//   sout_lsb  out  1      q[0], bit leaving on shift right
//   sout_msb  out  1      q[WIDTH-1], bit leaving on shift left
//   bit_cnt   out  CNT_W  shifts since last load/reset, saturating at WIDTH
//   done      out  1      one-cycle pulse on the WIDTH-th shift
module shift_reg_universal #(
   parameter int unsigned      WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   // Derived; do not override.
   parameter int unsigned      CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_msb,
   input  logic             sin_lsb,
`ifdef ROTATE_EN
   input  logic             rot,
`endif
   output logic [WIDTH-1:0] q,
   output logic             sout_lsb,
   output logic             sout_msb,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             done
);

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             fill_msb, fill_lsb;
   logic             shift_en;

   // Bits entering the register on a shift: serial inputs or the wrapped end.
   always_comb begin
`ifdef ROTATE_EN
      fill_msb = rot ? q_q[0]       : sin_msb;
      fill_lsb = rot ? q_q[WIDTH-1] : sin_lsb;
`else
      fill_msb = sin_msb;
      fill_lsb = sin_lsb;
`endif
   end

   always_comb begin
      q_d      = q_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      shift_en = 1'b0;
      case (mode)
         MODE_HOLD: ;
         MODE_SHR: begin
            q_d      = {fill_msb, q_q[WIDTH-1:1]};
            shift_en = 1'b1;
         end
         MODE_SHL: begin
            q_d      = {q_q[WIDTH-2:0], fill_lsb};
            shift_en = 1'b1;
         end
         MODE_LOAD: begin
            q_d   = d;
            cnt_d = '0;
         end
         default: ;
      endcase
      // Counter stops at WIDTH, so done fires only on the transition into it.
      if (shift_en && (cnt_q != CNT_MAX)) begin
         cnt_d  = cnt_q + CNT_W'(1);
         done_d = (cnt_q == CNT_MAX - CNT_W'(1));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q    <= RESET_VAL;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign q        = q_q;
   assign sout_lsb = q_q[0];
   assign sout_msb = q_q[WIDTH-1];
   assign bit_cnt  = cnt_q;
   assign done     = done_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench for shift_reg_universal at WIDTH=4, RESET_VAL=0.
// Inputs are driven on the falling edge and outputs checked on the next
// falling edge, i.e. one rising edge later.
module tb_shift_reg_universal;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] mode;
   logic [3:0] d;
   logic       sin_msb;
   logic       sin_lsb;
   logic       rot;
   logic [3:0] q;
   logic       sout_lsb;
   logic       sout_msb;
   logic [2:0] bit_cnt;
   logic       done;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   shift_reg_universal #(
      .WIDTH     (4),
      .RESET_VAL (4'h0)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .mode     (mode),
      .d        (d),
      .sin_msb  (sin_msb),
      .sin_lsb  (sin_lsb),
`ifdef ROTATE_EN
      .rot      (rot),
`endif
      .q        (q),
      .sout_lsb (sout_lsb),
      .sout_msb (sout_msb),
      .bit_cnt  (bit_cnt),
      .done     (done)
   );

   typedef struct {
      logic [1:0] mode;
      logic [3:0] d;
      logic       sm;
      logic       sl;
      logic [3:0] exp_q;
      logic [2:0] exp_cnt;
      logic       exp_done;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] m, input logic [3:0] dd, input logic sm,
                      input logic sl, input logic [3:0] eq, input logic [2:0] ec,
                      input logic ed);
      vec_t v;
      v.mode = m; v.d = dd; v.sm = sm; v.sl = sl;
      v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [3:0] eq, input logic [2:0] ec,
                              input logic ed);
      logic [3:0] e;
      e = eq;
      check({tag, " q"}, 32'(q), 32'(eq));
      check({tag, " bit_cnt"}, 32'(bit_cnt), 32'(ec));
      check({tag, " done"}, 32'(done), 32'(ed));
      check({tag, " sout_lsb"}, 32'(sout_lsb), 32'(e[0]));
      check({tag, " sout_msb"}, 32'(sout_msb), 32'(e[3]));
   endtask

   task automatic drive(input logic [1:0] m, input logic [3:0] dd, input logic sm,
                        input logic sl);
      mode = m; d = dd; sin_msb = sm; sin_lsb = sl;
   endtask

   initial begin
      reset_n = 1'b0;
      rot     = 1'b0;
      drive(2'b00, 4'h0, 1'b0, 1'b0);
      #1;
      check_state("reset", 4'h0, 3'd0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      // PISO of 4'hB: bits leave sout_lsb as 1,1,0,1 (checked before each shift).
      add(2'b11, 4'hB, 0, 0, 4'hB, 3'd0, 0);
      add(2'b01, 4'h0, 0, 0, 4'h5, 3'd1, 0);
      add(2'b01, 4'h0, 0, 0, 4'h2, 3'd2, 0);
      add(2'b01, 4'h0, 0, 0, 4'h1, 3'd3, 0);
      add(2'b01, 4'h0, 0, 0, 4'h0, 3'd4, 1);
      // Saturation: no re-pulse.
      add(2'b01, 4'h0, 0, 0, 4'h0, 3'd4, 0);
      add(2'b10, 4'h0, 0, 0, 4'h0, 3'd4, 0);
      add(2'b01, 4'h0, 0, 0, 4'h0, 3'd4, 0);
      // SIPO from 0: sin_lsb 1,0,1,1 -> 4'hB.
      add(2'b11, 4'h0, 0, 0, 4'h0, 3'd0, 0);
      add(2'b10, 4'h0, 0, 1, 4'h1, 3'd1, 0);
      add(2'b10, 4'h0, 0, 0, 4'h2, 3'd2, 0);
      add(2'b10, 4'h0, 0, 1, 4'h5, 3'd3, 0);
      add(2'b10, 4'h0, 0, 1, 4'hB, 3'd4, 1);
      // Mixed shifts, hold with changing d, then an aborting load.
      add(2'b11, 4'h5, 0, 0, 4'h5, 3'd0, 0);
      add(2'b01, 4'h0, 1, 0, 4'hA, 3'd1, 0);
      add(2'b10, 4'h0, 1, 0, 4'h4, 3'd2, 0);
      add(2'b00, 4'hF, 1, 1, 4'h4, 3'd2, 0);
      add(2'b00, 4'h3, 0, 1, 4'h4, 3'd2, 0);
      add(2'b00, 4'h9, 1, 0, 4'h4, 3'd2, 0);
      add(2'b11, 4'hC, 0, 0, 4'hC, 3'd0, 0);
      add(2'b01, 4'h0, 1, 0, 4'hE, 3'd1, 0);
      add(2'b10, 4'h0, 0, 1, 4'hD, 3'd2, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].mode, vecs[i].d, vecs[i].sm, vecs[i].sl);
         @(negedge clk);
         check_state($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt,
                     vecs[i].exp_done);
      end

      // Asynchronous reset mid-run, away from any clock edge.
      drive(2'b11, 4'h0, 0, 0); @(negedge clk);
      drive(2'b10, 4'h0, 0, 1); @(negedge clk);
      drive(2'b10, 4'h0, 0, 0); @(negedge clk);
      drive(2'b10, 4'h0, 0, 1); @(negedge clk);
      drive(2'b10, 4'h0, 0, 0); @(negedge clk);
      check_state("pre_rst", 4'hA, 3'd4, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      check_state("async_rst", 4'h0, 3'd0, 1'b0);
      #1 reset_n = 1'b1;
      drive(2'b11, 4'h7, 0, 0);
      @(negedge clk);
      check_state("post_rst_load", 4'h7, 3'd0, 1'b0);

`ifdef ROTATE_EN
      // Rotation ignores sin_* and still counts as shifts.
      drive(2'b11, 4'h9, 1, 1); @(negedge clk);
      check_state("rot_load", 4'h9, 3'd0, 1'b0);
      rot = 1'b1;
      drive(2'b10, 4'h0, 0, 0); @(negedge clk);
      check_state("rot_l", 4'h3, 3'd1, 1'b0);
      drive(2'b01, 4'h0, 1, 1); @(negedge clk);
      check_state("rot_r1", 4'h9, 3'd2, 1'b0);
      drive(2'b01, 4'h0, 0, 1); @(negedge clk);
      check_state("rot_r2", 4'hC, 3'd3, 1'b0);
      drive(2'b00, 4'h0, 1, 1); @(negedge clk);
      check_state("rot_hold", 4'hC, 3'd3, 1'b0);
      drive(2'b10, 4'h0, 0, 0); @(negedge clk);
      check_state("rot_done", 4'h9, 3'd4, 1'b1);
      rot = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
